reg_pipe: RTL
=============

REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of register stages; legal range 1..16.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset; clears all state immediately on assertion, independent of clk.
REQ-005 flush  input  1  synchronous clear of all stage valid bits, sampled on posedge clk.
REQ-006 in_valid  input  1  upstream word present on in_data.
REQ-007 in_data  input  WIDTH  upstream word.
REQ-008 in_ready  output  1  pipeline accepts in_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid word (stage DEPTH-1 valid bit).
REQ-010 out_data  output  WIDTH  last-stage data register, driven directly from the flop.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-012 Each stage i (0..DEPTH-1) SHALL hold one data register of WIDTH bits and one valid bit v[i].
REQ-013 Output handshake completes on a cycle with out_valid=1 and out_ready=1.
REQ-014 Stage DEPTH-1 advance enable SHALL be adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
REQ-015 Stage i<DEPTH-1 advance enable SHALL be adv[i] = !v[i] | adv[i+1], giving bubble collapse: an empty stage SHALL be filled even when downstream stages are stalled.
REQ-016 in_ready SHALL equal adv[0] & !flush; it is combinational from out_ready and the valid bits.
REQ-017 When adv[i]=1, stage i loads the data and valid of stage i-1 (stage 0 loads in_data and in_valid & in_ready); when adv[i]=0, stage i holds data and valid.
REQ-018 Data registers SHALL NOT change when their stage does not advance; an invalid word may be loaded into a stage (valid=0), in which case its data value is don't-care.
REQ-019 Latency with no stalls SHALL be DEPTH cycles from input handshake to out_valid=1; sustained throughput SHALL be one word per cycle.
REQ-020 Words SHALL leave in acceptance order, with no loss and no duplication.
REQ-021 flush=1 SHALL clear every v[i] at the next edge, override all advances, block input acceptance that cycle, and leave data registers unchanged; an output handshake coincident with flush counts as completed.
REQ-022 in_valid=1 with in_ready=0 SHALL NOT be captured; upstream holds in_data until handshake.
REQ-023 DEPTH=1 SHALL act as a single full-throughput register slice (in_ready = !v[0] | out_ready).

Reset
REQ-024 On rst assertion, all v[i] SHALL clear to 0 and all data registers to 0 asynchronously.
REQ-025 Consequently, during and after reset, out_valid=0 and out_data=0, and in_ready equals !flush.
REQ-026 rst deassertion is assumed synchronised externally; the first handshake is possible on the first edge after deassertion.
REQ-027 Reset mid-stream SHALL discard all held words with no partial output.

Configuration
REQ-028 With REG_PIPE_OCC_EN defined, an extra output occupancy (width $clog2(DEPTH+1)) SHALL give the registered count of valid stages; it is reset to 0, is 0 the cycle after flush, and is updated each edge by +1 accept, -1 output handshake, and unchanged when both occur together.
REQ-029 Without REG_PIPE_OCC_EN, the port and its counter SHALL be absent and all other behaviour is identical.

Structure
REQ-030 Package reg_pipe_pkg SHALL hold the default WIDTH and DEPTH localparams and an occupancy-width function (clog2 of DEPTH+1).
REQ-031 One stage (valid flop, data flop, advance mux) SHALL be sub-module reg_pipe_stage, instantiated DEPTH times via generate.

Verification
REQ-032 Streaming: DEPTH=4, WIDTH=8, out_ready=1, inputs 0x01..0x08 on consecutive cycles -> out_data 0x01..0x08 on consecutive cycles, the first 4 cycles after its accept.
REQ-033 Stall and fill: push 0xA1 and 0xA2, out_ready=0 -> both collapse to stages 3 and 2; in_ready stays 1 until 4 words are held, then drops to 0; release out_ready -> 0xA1 appears first, and in_ready=1 the same cycle.
REQ-034 Flush: 3 words held, flush=1 with in_valid=1 -> in_ready=0 that cycle; next cycle out_valid=0 and occupancy=0 (macro on); the next pushed 0x55 emerges after 4 cycles.
REQ-035 Async reset: assert rst between edges while full -> out_valid=0 and out_data=0 immediately, before the next edge.
REQ-036 Random back-pressure: 10k cycles, random in_valid and out_ready at 50% each -> scoreboard shows an exact in-order match, and the occupancy counter equals the count of set valid bits every cycle.
REQ-037 DEPTH=1: simultaneous accept and output every cycle -> one word per cycle, and in_ready is never low while out_ready=1.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// Shared defaults and helpers for the reg_pipe register pipeline.
package reg_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: a valid flop and a data flop, each loading from the
// previous stage when the stage advances and holding otherwise.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Valid bit: flush beats advance; otherwise load on advance, else hold.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state flops use non-blocking assignments so every stage samples
        // its neighbour's pre-edge value, independent of evaluation order.
        if (rst) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (adv) begin
            valid <= in_valid;
        end
    end

    // Data register: loads only on a real advance; flush leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the data flop is reset only because out_data must read 0 after
        // reset; a pure datapath register would normally skip this reset.
        if (rst) begin
            data <= '0;
        end else if (adv && !flush) begin
            data <= in_data;
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse.
// Optional feature: define REG_PIPE_OCC_EN to add the registered 'occupancy'
// output (count of valid stages). Without it the port and counter are absent.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
`ifdef REG_PIPE_OCC_EN
    output logic [occ_width(DEPTH)-1:0] occupancy,
`endif
    input  logic             out_ready
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic             accept;

    // Advance chain: a stage moves when it is empty or the stage after it moves,
    // so an empty slot is filled even while the tail is stalled.
    always_comb begin
        // NOTE: assign a default before any conditional update so no path leaves
        // adv unassigned, which would otherwise infer a latch.
        adv          = '0;
        adv[DEPTH-1] = !v[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = !v[i] | adv[i+1];
        end
    end

    assign in_ready  = adv[0] & !flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             stg_in_valid;
        logic [WIDTH-1:0] stg_in_data;

        if (i == 0) begin : g_head
            assign stg_in_valid = accept;
            assign stg_in_data  = in_data;
        end else begin : g_body
            assign stg_in_valid = v[i-1];
            assign stg_in_data  = d[i-1];
        end

        reg_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .adv     (adv[i]),
            .in_valid(stg_in_valid),
            .in_data (stg_in_data),
            .valid   (v[i]),
            .data    (d[i])
        );
    end

`ifdef REG_PIPE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    logic             out_hs;
    logic [OCC_W-1:0] occ_q;

    assign out_hs    = out_valid & out_ready;
    assign occupancy = occ_q;

    // Occupancy: +1 on accept, -1 on output handshake, cleared by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else begin
            case ({accept, out_hs})
                2'b10:   occ_q <= occ_q + OCC_ONE;
                2'b01:   occ_q <= occ_q - OCC_ONE;
                default: occ_q <= occ_q;
            endcase
        end
    end
`endif

endmodule
